// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scanner and its row encoder.
package keypad_pkg;

  // Scanner FSM states; also exported on the debug state port.
  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } keypad_state_t;

  // Reported key: {row_idx[1:0], col_idx[1:0]}.
  typedef logic [3:0] key_code_t;

  // Active-low rows with nothing pressed.
  localparam logic [3:0] ROWS_IDLE = 4'b1111;

  // Active-low one-cold strobe for a column index.
  function automatic logic [3:0] col_strobe(input logic [1:0] col);
    col_strobe = ~(4'b0001 << col);
  endfunction

endpackage

// File: rtl/module_row_encoder.sv
// Priority encoder for active-low keypad rows; row 0 wins when several are low.
module module_row_encoder
  import keypad_pkg::*;
(
  input  logic [3:0] rows,
  output logic [1:0] row_idx,
  output logic       any_low
);

  // Pick the lowest-numbered low row and flag whether any row is low.
  always_comb begin
    row_idx = 2'd0;
    any_low = (rows != ROWS_IDLE);
    if (!rows[0])      row_idx = 2'd0;
    else if (!rows[1]) row_idx = 2'd1;
    else if (!rows[2]) row_idx = 2'd2;
    else if (!rows[3]) row_idx = 2'd3;
  end

endmodule

// File: rtl/module_keypad_scanner.sv
// 4x4 keypad scanner: strobes columns, debounces press and release, reports
// one key at a time (no rollover).
//
// Output handshake: key_valid is a one-cycle pulse with no ready/back-pressure.
// key_code is stable from the key_valid cycle until the next key_valid, and
// key_held stays high from the key_valid cycle until the release is accepted.
module module_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS     = 1000,
  parameter int DEBOUNCE_TICKS = 10000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    sync_rows,
  output logic [3:0]    col_drive,
  output logic [3:0]    key_code,
  output logic          key_valid,
  output logic          key_held,
  output keypad_state_t dbg_state
);

  localparam int CNT_MAX = (SCAN_TICKS > DEBOUNCE_TICKS) ? SCAN_TICKS : DEBOUNCE_TICKS;
  localparam int CW      = $clog2(CNT_MAX + 1);

  // Terminal counts: scan samples on its last tick; debounce confirms after
  // DEBOUNCE_TICKS matches (giving DEBOUNCE_TICKS+1 cycles of latency);
  // release exits on the DEBOUNCE_TICKS-th consecutive idle cycle.
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_TICKS - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_TICKS);
  localparam logic [CW-1:0] REL_LAST  = CW'(DEBOUNCE_TICKS - 1);

  keypad_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    col, col_n;
  logic [3:0]    pattern, pattern_n;
  key_code_t     code_q, code_n;
  logic          held_q, held_n;

  logic [1:0]    row_idx;
  logic          row_any;

  module_row_encoder u_row_encoder (
    .rows    (pattern),
    .row_idx (row_idx),
    .any_low (row_any)
  );

  // State and datapath registers; reset aborts any press in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_SCAN;
      cnt     <= '0;
      col     <= 2'd0;
      pattern <= ROWS_IDLE;
      code_q  <= '0;
      held_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      col     <= col_n;
      pattern <= pattern_n;
      code_q  <= code_n;
      held_q  <= held_n;
    end
  end

  // Next-state and next-datapath logic for scan / debounce / press / release.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    col_n     = col;
    pattern_n = pattern;
    code_n    = code_q;
    held_n    = held_q;
    case (state)
      ST_SCAN: begin
        if (cnt == SCAN_LAST) begin
          cnt_n = '0;
          if (sync_rows == ROWS_IDLE) begin
            col_n = col + 2'd1;
          end else begin
            pattern_n = sync_rows;
            state_n   = ST_DEBOUNCE;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (sync_rows != pattern) begin
          // Bounce: rescan the same column from the start.
          state_n   = ST_SCAN;
          cnt_n     = '0;
          pattern_n = ROWS_IDLE;
        end else if (cnt == DEB_LAST && row_any) begin
          // Load the report so it is already valid during ST_PRESSED.
          state_n = ST_PRESSED;
          cnt_n   = '0;
          code_n  = {row_idx, col};
          held_n  = 1'b1;
        end else if (cnt != DEB_LAST) begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_PRESSED: begin
        state_n = ST_RELEASE;
        cnt_n   = '0;
      end
      ST_RELEASE: begin
        // Column stays put so a second key on another column is ignored.
        if (sync_rows != ROWS_IDLE) begin
          cnt_n = '0;
        end else if (cnt == REL_LAST) begin
          state_n   = ST_SCAN;
          cnt_n     = '0;
          held_n    = 1'b0;
          col_n     = col + 2'd1;
          pattern_n = ROWS_IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = ST_SCAN;
        cnt_n   = '0;
      end
    endcase
  end

  assign col_drive = col_strobe(col);
  assign key_code  = code_q;
  assign key_valid = (state == ST_PRESSED);
  assign key_held  = held_q;
  assign dbg_state = state;

endmodule

// File: doc/module_keypad_scanner.md
MODULE_KEYPAD_SCANNER -- requirements
Module: module_keypad_scanner

Interface
REQ-001 Parameter SCAN_TICKS, default 1000: clk cycles each column is driven before its rows are sampled.
REQ-002 Parameter DEBOUNCE_TICKS, default 10000: consecutive stable cycles required to accept a press or a release.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 sync_rows  input  4  synchronized keypad rows, active-low, 4'b1111 = no key.
REQ-006 col_drive  output  4  column strobe, active-low, exactly one bit low at all times.
REQ-007 key_code  output  4  last accepted key, {row_idx[1:0], col_idx[1:0]}.
REQ-008 key_valid  output  1  one-cycle pulse when key_code is updated.
REQ-009 key_held  output  1  high from the key_valid cycle until the release is accepted.

Function
REQ-010 The block SHALL implement the FSM states SCAN, DEBOUNCE, PRESSED and RELEASE.
REQ-011 SCAN SHALL drive column col_idx low, count 0..SCAN_TICKS-1, and sample sync_rows when the count equals SCAN_TICKS-1.
REQ-012 If a SCAN sample is 4'b1111, col_idx SHALL advance modulo 4 (3 -> 0) and the counter SHALL clear.
REQ-013 If a SCAN sample is not 4'b1111, the block SHALL latch the row pattern, hold col_idx, clear the counter and enter DEBOUNCE.
REQ-014 DEBOUNCE SHALL compare sync_rows with the latched pattern every cycle; on mismatch it SHALL return to SCAN on the same col_idx with the counter cleared.
REQ-015 After DEBOUNCE_TICKS consecutive matching cycles, DEBOUNCE SHALL enter PRESSED.
REQ-016 PRESSED SHALL last exactly one cycle: key_valid=1, key_code={row_idx,col_idx}, key_held set; next state RELEASE.
REQ-017 If more than one latched row is low, row_idx SHALL be the lowest-numbered low row (row 0 highest priority).
REQ-018 RELEASE SHALL hold col_idx and count consecutive cycles with sync_rows == 4'b1111; any low row SHALL clear the count.
REQ-019 After DEBOUNCE_TICKS consecutive idle cycles, RELEASE SHALL clear key_held, advance col_idx modulo 4 and enter SCAN with the counter cleared.
REQ-020 A second key pressed while in RELEASE SHALL NOT be reported until the first release is accepted (no rollover).
REQ-021 key_code SHALL hold its value outside PRESSED; key_valid SHALL be 0 in every state except PRESSED.
REQ-022 Latency SHALL be exactly DEBOUNCE_TICKS+1 cycles from the SCAN sampling edge to the key_valid edge for a bounce-free press.
REQ-023 The counter width SHALL be $clog2 of max(SCAN_TICKS, DEBOUNCE_TICKS)+1 and SHALL never wrap past its terminal value.

Reset
REQ-024 On rst, state=SCAN, col_idx=0, col_drive=4'b1110, counter=0, latched pattern=4'b1111, key_code=0, key_valid=0, key_held=0.
REQ-025 Reset asserted mid-operation (any state) SHALL abort it immediately; no key_valid pulse SHALL be produced for the aborted press.

Structure
REQ-026 A shared package keypad_pkg SHALL hold the state enum type, the key-code typedef (4 bits) and the idle-row constant 4'b1111.
REQ-027 The row priority encoder SHALL be a sub-module named module_row_encoder (4-bit active-low in, 2-bit index plus any-low flag out).
REQ-028 sync_rows SHALL be connected directly to the synchronizer output; this block SHALL add no further input synchronization.

Verification (SCAN_TICKS=4, DEBOUNCE_TICKS=8)
REQ-029 Idle rows 4'b1111 for 40 cycles -> col_drive cycles 1110,1101,1011,0111,1110 every 4 cycles; key_valid never asserts.
REQ-030 Row 2 held low while column 1 is driven -> exactly one key_valid pulse, 9 cycles after the sample, with key_code=4'b1001, key_held=1.
REQ-031 Row 0 low for 3 cycles then high (bounce) -> return to SCAN on column unchanged; no key_valid pulse.
REQ-032 Rows 1 and 3 low together on column 3 -> key_code=4'b0111.
REQ-033 Key held 50 cycles, then released with a 2-cycle glitch low at release cycle 5 -> key_held stays 1 until 8 consecutive idle cycles after the glitch, then 0; no second key_valid.
REQ-034 rst pulsed during DEBOUNCE -> outputs at their REQ-024 values on the next edge; no key_valid pulse.
